reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_if.sv | 38 +++
 rtl/reservation_station.sv | 167 ++++++++++++++++
 tb/tb_reservation_station.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_if.sv
// Issue, result-broadcast and dispatch bundle of the reservation station.
// master = decode/ROB side driving issue and broadcasts, slave = the station.
interface reservation_station_if #(
  parameter int ID_WIDTH  = 4,
  parameter int VAL_WIDTH = 32,
  parameter int OP_WIDTH  = 6
);
  logic                 issue_valid;
  logic [OP_WIDTH-1:0]  issue_op;
  logic [ID_WIDTH-1:0]  issue_rob_id;
  logic                 issue_rdy1, issue_rdy2;
  logic [ID_WIDTH-1:0]  issue_q1, issue_q2;
  logic [VAL_WIDTH-1:0] issue_v1, issue_v2;
  logic [VAL_WIDTH-1:0] issue_imm;
  logic [31:0]          issue_pc;
  logic                 cdb_valid, alu_valid;
  logic [ID_WIDTH-1:0]  cdb_id, alu_id;
  logic [VAL_WIDTH-1:0] cdb_val, alu_val;
  logic                 rs_full;
  logic                 exe_valid;
  logic [OP_WIDTH-1:0]  exe_op;
  logic [VAL_WIDTH-1:0] exe_v1, exe_v2, exe_imm;
  logic [31:0]          exe_pc;
  logic [ID_WIDTH-1:0]  exe_rob_id;

  modport master (
    output issue_valid, issue_op, issue_rob_id, issue_rdy1, issue_rdy2, issue_q1, issue_q2,
           issue_v1, issue_v2, issue_imm, issue_pc, cdb_valid, cdb_id, cdb_val,
           alu_valid, alu_id, alu_val,
    input  rs_full, exe_valid, exe_op, exe_v1, exe_v2, exe_imm, exe_pc, exe_rob_id
  );
  modport slave (
    input  issue_valid, issue_op, issue_rob_id, issue_rdy1, issue_rdy2, issue_q1, issue_q2,
           issue_v1, issue_v2, issue_imm, issue_pc, cdb_valid, cdb_id, cdb_val,
           alu_valid, alu_id, alu_val,
    output rs_full, exe_valid, exe_op, exe_v1, exe_v2, exe_imm, exe_pc, exe_rob_id
  );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: in-order-lowest-index allocation, tag wakeup from
// cdb/alu broadcasts, and lowest-index-ready dispatch into a registered exe stage.
module rs_entry #(
  parameter int ID_WIDTH  = 4,
  parameter int VAL_WIDTH = 32,
  parameter int OP_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 alloc,
  input  logic                 clr,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic [ID_WIDTH-1:0]  in_rob_id,
  input  logic                 in_rdy1, in_rdy2,
  input  logic [ID_WIDTH-1:0]  in_q1, in_q2,
  input  logic [VAL_WIDTH-1:0] in_v1, in_v2, in_imm,
  input  logic [31:0]          in_pc,
  input  logic                 cdb_valid, alu_valid,
  input  logic [ID_WIDTH-1:0]  cdb_id, alu_id,
  input  logic [VAL_WIDTH-1:0] cdb_val, alu_val,
  output logic                 busy,
  output logic                 ready,
  output logic [OP_WIDTH-1:0]  op,
  output logic [ID_WIDTH-1:0]  rob_id,
  output logic [VAL_WIDTH-1:0] v1, v2, imm,
  output logic [31:0]          pc
);
  logic                rdy1, rdy2;
  logic [ID_WIDTH-1:0] q1, q2;

  assign ready = busy & rdy1 & rdy2;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      rdy1 <= 1'b0;
      rdy2 <= 1'b0;
    end else if (en) begin
      if (flush) begin
        busy <= 1'b0;
      end else if (alloc) begin
        busy   <= 1'b1;
        op     <= in_op;
        rob_id <= in_rob_id;
        rdy1   <= in_rdy1;
        rdy2   <= in_rdy2;
        q1     <= in_q1;
        q2     <= in_q2;
        v1     <= in_v1;
        v2     <= in_v2;
        imm    <= in_imm;
        pc     <= in_pc;
      end else begin
        if (clr) busy <= 1'b0;
        // cdb wins when both buses claim the same tag
        if (busy && !rdy1) begin
          if (cdb_valid && cdb_id == q1)      begin rdy1 <= 1'b1; v1 <= cdb_val; end
          else if (alu_valid && alu_id == q1) begin rdy1 <= 1'b1; v1 <= alu_val; end
        end
        if (busy && !rdy2) begin
          if (cdb_valid && cdb_id == q2)      begin rdy2 <= 1'b1; v2 <= cdb_val; end
          else if (alu_valid && alu_id == q2) begin rdy2 <= 1'b1; v2 <= alu_val; end
        end
      end
    end
  end
endmodule

module reservation_station #(
  parameter int RS_SIZE   = 8,
  parameter int ID_WIDTH  = 4,
  parameter int VAL_WIDTH = 32,
  parameter int OP_WIDTH  = 6
) (
  input  logic clk,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush_in,
  reservation_station_if.slave bus
);
  localparam int IW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]                busy, ready;
  logic [RS_SIZE-1:0][OP_WIDTH-1:0]  e_op;
  logic [RS_SIZE-1:0][ID_WIDTH-1:0]  e_rob_id;
  logic [RS_SIZE-1:0][VAL_WIDTH-1:0] e_v1, e_v2, e_imm;
  logic [RS_SIZE-1:0][31:0]          e_pc;
  logic [IW-1:0]                     free_idx, sel_idx;
  logic                              any_sel, take_issue;
  logic                              byp_rdy1, byp_rdy2;
  logic [VAL_WIDTH-1:0]              byp_v1, byp_v2;

  assign bus.rs_full = &busy;
  assign take_issue  = bus.issue_valid & ~bus.rs_full & ~flush_in;

  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    any_sel  = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
      if (ready[i]) begin
        sel_idx = IW'(i);
        any_sel = 1'b1;
      end
    end
  end

  // Same-cycle broadcast is captured at issue so the tag is never missed
  always_comb begin
    byp_rdy1 = bus.issue_rdy1;
    byp_v1   = bus.issue_v1;
    byp_rdy2 = bus.issue_rdy2;
    byp_v2   = bus.issue_v2;
    if (!bus.issue_rdy1) begin
      if (bus.cdb_valid && bus.cdb_id == bus.issue_q1)      begin byp_rdy1 = 1'b1; byp_v1 = bus.cdb_val; end
      else if (bus.alu_valid && bus.alu_id == bus.issue_q1) begin byp_rdy1 = 1'b1; byp_v1 = bus.alu_val; end
    end
    if (!bus.issue_rdy2) begin
      if (bus.cdb_valid && bus.cdb_id == bus.issue_q2)      begin byp_rdy2 = 1'b1; byp_v2 = bus.cdb_val; end
      else if (bus.alu_valid && bus.alu_id == bus.issue_q2) begin byp_rdy2 = 1'b1; byp_v2 = bus.alu_val; end
    end
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    rs_entry #(.ID_WIDTH(ID_WIDTH), .VAL_WIDTH(VAL_WIDTH), .OP_WIDTH(OP_WIDTH)) u_ent (
      .clk(clk), .rst(rst_in), .en(rdy_in), .flush(flush_in),
      .alloc(take_issue && free_idx == IW'(g)),
      .clr(any_sel && sel_idx == IW'(g)),
      .in_op(bus.issue_op), .in_rob_id(bus.issue_rob_id),
      .in_rdy1(byp_rdy1), .in_rdy2(byp_rdy2), .in_q1(bus.issue_q1), .in_q2(bus.issue_q2),
      .in_v1(byp_v1), .in_v2(byp_v2), .in_imm(bus.issue_imm), .in_pc(bus.issue_pc),
      .cdb_valid(bus.cdb_valid), .alu_valid(bus.alu_valid),
      .cdb_id(bus.cdb_id), .alu_id(bus.alu_id), .cdb_val(bus.cdb_val), .alu_val(bus.alu_val),
      .busy(busy[g]), .ready(ready[g]), .op(e_op[g]), .rob_id(e_rob_id[g]),
      .v1(e_v1[g]), .v2(e_v2[g]), .imm(e_imm[g]), .pc(e_pc[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      bus.exe_valid  <= 1'b0;
      bus.exe_op     <= '0;
      bus.exe_v1     <= '0;
      bus.exe_v2     <= '0;
      bus.exe_imm    <= '0;
      bus.exe_pc     <= '0;
      bus.exe_rob_id <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        bus.exe_valid <= 1'b0;
      end else begin
        bus.exe_valid <= any_sel;
        if (any_sel) begin
          bus.exe_op     <= e_op[sel_idx];
          bus.exe_v1     <= e_v1[sel_idx];
          bus.exe_v2     <= e_v2[sel_idx];
          bus.exe_imm    <= e_imm[sel_idx];
          bus.exe_pc     <= e_pc[sel_idx];
          bus.exe_rob_id <= e_rob_id[sel_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Directed-vector bench for reservation_station: issue, wakeup, bypass,
// full/ordering, flush, stall and mid-operation reset.
module tb_reservation_station;
  logic clk = 1'b0;
  logic rst_in, rdy_in, flush_in;
  int   nvec = 0;
  int   nerr = 0;

  reservation_station_if #(.ID_WIDTH(4), .VAL_WIDTH(32), .OP_WIDTH(6)) bus ();

  reservation_station #(.RS_SIZE(8), .ID_WIDTH(4), .VAL_WIDTH(32), .OP_WIDTH(6)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] rob, input logic r1, input logic [3:0] q1,
                       input logic [31:0] v1, input logic r2, input logic [3:0] q2,
                       input logic [31:0] v2);
    bus.issue_valid  = 1'b1;
    bus.issue_op     = 6'(rob) + 6'd1;
    bus.issue_rob_id = rob;
    bus.issue_rdy1   = r1;
    bus.issue_q1     = q1;
    bus.issue_v1     = v1;
    bus.issue_rdy2   = r2;
    bus.issue_q2     = q2;
    bus.issue_v2     = v2;
    bus.issue_imm    = 32'h1000 + 32'(rob);
    bus.issue_pc     = 32'h400 + 32'(rob) * 4;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_rob_id = '0;
    bus.issue_rdy1 = 1'b0; bus.issue_rdy2 = 1'b0; bus.issue_q1 = '0; bus.issue_q2 = '0;
    bus.issue_v1 = '0; bus.issue_v2 = '0; bus.issue_imm = '0; bus.issue_pc = '0;
    bus.cdb_valid = 1'b0; bus.cdb_id = '0; bus.cdb_val = '0;
    bus.alu_valid = 1'b0; bus.alu_id = '0; bus.alu_val = '0;
    step(); step();
    rst_in = 1'b0;
    chk("rst_exe_valid", 32'(bus.exe_valid), 0);
    chk("rst_exe_v1", bus.exe_v1, 0);
    chk("rst_exe_pc", bus.exe_pc, 0);
    chk("rst_exe_rob", 32'(bus.exe_rob_id), 0);
    chk("rst_full", 32'(bus.rs_full), 0);

    // ready issue: dispatch exactly one edge after the issue edge
    issue(4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
    step(); bus.issue_valid = 1'b0;
    chk("rdy_early", 32'(bus.exe_valid), 0);
    step();
    chk("rdy_valid", 32'(bus.exe_valid), 1);
    chk("rdy_v1", bus.exe_v1, 5);
    chk("rdy_v2", bus.exe_v2, 7);
    chk("rdy_rob", 32'(bus.exe_rob_id), 3);
    chk("rdy_op", 32'(bus.exe_op), 4);
    chk("rdy_pc", bus.exe_pc, 32'h40c);
    chk("rdy_imm", bus.exe_imm, 32'h1003);
    step();
    chk("rdy_pulse", 32'(bus.exe_valid), 0);
    chk("rdy_hold_v1", bus.exe_v1, 5);

    // wakeup on alu bus
    issue(4'd4, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd1);
    step(); bus.issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wake_wait", 32'(bus.exe_valid), 0);
    end
    bus.alu_valid = 1'b1; bus.alu_id = 4'd2; bus.alu_val = 32'h10;
    step(); bus.alu_valid = 1'b0;
    chk("wake_early", 32'(bus.exe_valid), 0);
    step();
    chk("wake_valid", 32'(bus.exe_valid), 1);
    chk("wake_v1", bus.exe_v1, 32'h10);
    chk("wake_rob", 32'(bus.exe_rob_id), 4);
    step();

    // issue bypass from cdb
    issue(4'd5, 1'b1, 4'd0, 32'd1, 1'b0, 4'd6, 32'd0);
    bus.cdb_valid = 1'b1; bus.cdb_id = 4'd6; bus.cdb_val = 32'hAB;
    step(); bus.issue_valid = 1'b0; bus.cdb_valid = 1'b0;
    chk("byp_early", 32'(bus.exe_valid), 0);
    step();
    chk("byp_valid", 32'(bus.exe_valid), 1);
    chk("byp_v2", bus.exe_v2, 32'hAB);
    step();

    // cdb beats alu on the same tag
    issue(4'd6, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd2);
    step(); bus.issue_valid = 1'b0;
    bus.cdb_valid = 1'b1; bus.cdb_id = 4'd7; bus.cdb_val = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_id = 4'd7; bus.alu_val = 32'h22;
    step(); bus.cdb_valid = 1'b0; bus.alu_valid = 1'b0;
    step();
    chk("prio_valid", 32'(bus.exe_valid), 1);
    chk("prio_v1", bus.exe_v1, 32'h11);
    step();

    // fill all 8 entries waiting on tag 9
    for (int i = 0; i < 8; i++) begin
      issue(4'(i), 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'(i));
      step();
      if (i == 6) chk("full_7of8", 32'(bus.rs_full), 0);
    end
    chk("full_set", 32'(bus.rs_full), 1);
    issue(4'd15, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    step(); bus.issue_valid = 1'b0;
    chk("full_hold", 32'(bus.rs_full), 1);
    chk("full_nodisp", 32'(bus.exe_valid), 0);
    bus.cdb_valid = 1'b1; bus.cdb_id = 4'd9; bus.cdb_val = 32'h99;
    step(); bus.cdb_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_valid", 32'(bus.exe_valid), 1);
      chk("drain_rob", 32'(bus.exe_rob_id), 32'(i));
      if (i == 0) chk("drain_full", 32'(bus.rs_full), 0);
    end
    chk("drain_v1", bus.exe_v1, 32'h99);
    step();
    chk("drain_end", 32'(bus.exe_valid), 0);

    // flush: 4 waiting + 1 ready entry, flush with a concurrent ready issue
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'd0);
      step();
    end
    issue(4'd11, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    step();
    issue(4'd12, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    flush_in = 1'b1;
    step(); flush_in = 1'b0; bus.issue_valid = 1'b0;
    chk("flush_full", 32'(bus.rs_full), 0);
    chk("flush_valid", 32'(bus.exe_valid), 0);
    bus.cdb_valid = 1'b1; bus.cdb_id = 4'd10; bus.cdb_val = 32'h5;
    step(); bus.cdb_valid = 1'b0;
    chk("flush_drop", 32'(bus.exe_valid), 0);
    step();
    chk("flush_nowake", 32'(bus.exe_valid), 0);

    // stall: broadcast and issue ignored while rdy_in is low
    issue(4'd6, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd3);
    step();
    rdy_in = 1'b0;
    issue(4'd13, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    bus.alu_valid = 1'b1; bus.alu_id = 4'd12; bus.alu_val = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(bus.exe_valid), 0);
    end
    rdy_in = 1'b1; bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
    step(); chk("stall_nowake", 32'(bus.exe_valid), 0);
    step(); chk("stall_noissue", 32'(bus.exe_valid), 0);
    bus.alu_valid = 1'b1; bus.alu_id = 4'd12; bus.alu_val = 32'h66;
    step(); bus.alu_valid = 1'b0;
    step();
    chk("stall_disp", 32'(bus.exe_valid), 1);
    chk("stall_v1", bus.exe_v1, 32'h66);
    rdy_in = 1'b0;
    step();
    chk("stall_hold", 32'(bus.exe_valid), 1);
    rdy_in = 1'b1;
    step();
    chk("stall_release", 32'(bus.exe_valid), 0);

    // reset mid-operation discards pending entries
    issue(4'd7, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'd0);
    step();
    issue(4'd8, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
    step(); bus.issue_valid = 1'b0;
    rst_in = 1'b1; rdy_in = 1'b0;
    step();
    rst_in = 1'b0; rdy_in = 1'b1;
    chk("mrst_valid", 32'(bus.exe_valid), 0);
    chk("mrst_v1", bus.exe_v1, 0);
    chk("mrst_v2", bus.exe_v2, 0);
    chk("mrst_op", 32'(bus.exe_op), 0);
    chk("mrst_imm", bus.exe_imm, 0);
    chk("mrst_pc", bus.exe_pc, 0);
    chk("mrst_full", 32'(bus.rs_full), 0);
    step();
    chk("mrst_nodisp", 32'(bus.exe_valid), 0);
    bus.alu_valid = 1'b1; bus.alu_id = 4'd13; bus.alu_val = 32'h7;
    step(); bus.alu_valid = 1'b0;
    step();
    chk("mrst_nowake", 32'(bus.exe_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
